next_pc_unit: RTL

//  Program-counter register and next-PC generator directly downstream of the PC-select stage.

---
 rtl/ozone_pc_pkg.sv | 17 +
 rtl/pred_tracker.sv | 93 +++++++++
 rtl/next_pc_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/ozone_pc_pkg.sv
// Shared constants for the PC generation path: select codes, FSM encodings, PC step.
package ozone_pc_pkg;

    localparam logic [1:0] SEL_SEQ      = 2'b00;
    localparam logic [1:0] SEL_PRED     = 2'b01;
    localparam logic [1:0] SEL_ISSUE    = 2'b10;
    localparam logic [1:0] SEL_ROLLBACK = 2'b11;

    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/pred_tracker.sv
// Outstanding-prediction counter with sticky underflow flag.
// With NEXT_PC_ALT_FIFO_EN it also keeps a FIFO of fall-through PCs, one per prediction.
module pred_tracker #(
    parameter int PC_W       = 32,
    parameter int PRED_DEPTH = 4,
    parameter int CNT_W      = $clog2(PRED_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
`ifdef NEXT_PC_ALT_FIFO_EN
    input  logic [PC_W-1:0]  push_pc_i,
    output logic [PC_W-1:0]  alt_pc_o,
    output logic             alt_valid_o,
`endif
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             err_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             pop_eff;
    logic             push_eff;

    // A pop with nothing outstanding is not counted; a push into a full tracker needs a pop.
    assign pop_eff  = pop_i & (count_q != '0);
    assign push_eff = push_i & (~full_o | pop_eff);

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (clear_i) begin
            count_d = '0;
        end else begin
            if (push_eff && !pop_eff) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - CNT_W'(1);
            end
            if (pop_i && (count_q == '0)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(PRED_DEPTH));
    assign err_o   = err_q;

`ifdef NEXT_PC_ALT_FIFO_EN
    localparam int PTR_W = $clog2(PRED_DEPTH);

    logic [PC_W-1:0]  mem_q [PRED_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff && !clear_i) begin
            mem_q[wr_ptr_q] <= push_pc_i;
        end
    end

    assign alt_pc_o    = mem_q[rd_ptr_q];
    assign alt_valid_o = (count_q != '0);
`endif

endmodule

// File: rtl/next_pc_unit.sv
// PC register, next-PC mux and fetch-stall FSM feeding instruction memory.
// Optional fall-through PC FIFO enabled by defining NEXT_PC_ALT_FIFO_EN.
module next_pc_unit
    import ozone_pc_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              PRED_DEPTH = 4,
    parameter int              CNT_W      = $clog2(PRED_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [PC_W-1:0]  pred_target,
    input  logic [PC_W-1:0]  issue_target,
    input  logic [PC_W-1:0]  rs_target,
    input  logic             pred_resolve,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [PC_W-1:0]  fetch_pc,
    output logic [CNT_W-1:0] pred_count,
    output logic             pred_full,
    output logic             pred_err,
`ifdef NEXT_PC_ALT_FIFO_EN
    output logic [PC_W-1:0]  pred_alt_pc,
    output logic             pred_alt_valid,
`endif
    output state_t           dbg_state
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));

    // Handshake: a fetch is taken on a cycle where fetch_valid and fetch_ready are both high;
    // rollback (sel==11) is not a handshake and takes effect on any cycle.
    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            accept;
    logic            rollback;
    logic            push;
    logic            make_full;

    assign accept    = fetch_valid & fetch_ready;
    assign rollback  = (sel == SEL_ROLLBACK);
    assign push      = accept & (sel == SEL_PRED);
    assign make_full = push & ~pred_resolve & (pred_count == CNT_W'(PRED_DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (make_full) state_d = ST_FULL;
            ST_FULL:  if (pred_resolve) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
        if (rollback) state_d = ST_FETCH;
    end

    always_comb begin
        fetch_valid = (state_q == ST_FETCH) | ((state_q == ST_FULL) & (sel != SEL_PRED));
        dbg_state   = state_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (rollback) begin
            fetch_pc_d = rs_target & ALIGN_MASK;
        end else if (accept) begin
            case (sel)
                SEL_SEQ:   fetch_pc_d = fetch_pc_q + PC_W'(PC_INCR);
                SEL_PRED:  fetch_pc_d = pred_target & ALIGN_MASK;
                SEL_ISSUE: fetch_pc_d = issue_target & ALIGN_MASK;
                default:   fetch_pc_d = fetch_pc_q;
            endcase
        end
    end

    assign fetch_pc = fetch_pc_q;

    pred_tracker #(
        .PC_W       (PC_W),
        .PRED_DEPTH (PRED_DEPTH),
        .CNT_W      (CNT_W)
    ) u_pred_tracker (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pred_resolve),
        .clear_i     (rollback),
`ifdef NEXT_PC_ALT_FIFO_EN
        .push_pc_i   (fetch_pc_q + PC_W'(PC_INCR)),
        .alt_pc_o    (pred_alt_pc),
        .alt_valid_o (pred_alt_valid),
`endif
        .count_o     (pred_count),
        .full_o      (pred_full),
        .err_o       (pred_err)
    );

endmodule
